aim_neuron: RTL and testbench

- Ternary-weight neuron ("AIM": add / ignore / minus) for the accelerator datapath.
- Takes 20 signed 9-bit activations and 20 signed 2-bit ternary weights, and forms the signed dot product with no multipliers.
- Each term is +A, -A or 0.
- Produces a saturated, registered 13-bit signed neuron output, two-stage pipelined.

---
 rtl/aim_neuron.sv | 141 ++++++++++++++
 tb/tb_aim_neuron.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aim_neuron.sv
// aim_neuron: ternary-weight ("add / ignore / minus") neuron.
//
// Forms the signed dot product of 20 activations with 20 ternary weights
// without any multipliers. Each lane contributes +A, -A or 0. The result is
// saturated to the OUT_W signed range and registered. There are two pipeline
// stages: per-lane terms, then the sum and saturation.
//
// Ports:
//   A1..A20     in  ACT_W  signed activations
//   W1..W20     in  2      ternary weights: 01=+1, 11=-1, 00=0, 10=reserved (0)
//   clk         in  1      rising-edge clock
//   rst         in  1      synchronous active-high reset; clears both stages
//   out_neuron  out OUT_W  signed saturated result, 2 edges after its inputs
//
// Optional feature: define AIM_RELU_EN to clamp negative results to 0 after
// saturation. The latency stays at 2.
module aim_neuron #(
  parameter int unsigned ACT_W = 9,
  parameter int unsigned OUT_W = 13
) (
  input  logic signed [ACT_W-1:0] A1,
  input  logic signed [ACT_W-1:0] A2,
  input  logic signed [ACT_W-1:0] A3,
  input  logic signed [ACT_W-1:0] A4,
  input  logic signed [ACT_W-1:0] A5,
  input  logic signed [ACT_W-1:0] A6,
  input  logic signed [ACT_W-1:0] A7,
  input  logic signed [ACT_W-1:0] A8,
  input  logic signed [ACT_W-1:0] A9,
  input  logic signed [ACT_W-1:0] A10,
  input  logic signed [ACT_W-1:0] A11,
  input  logic signed [ACT_W-1:0] A12,
  input  logic signed [ACT_W-1:0] A13,
  input  logic signed [ACT_W-1:0] A14,
  input  logic signed [ACT_W-1:0] A15,
  input  logic signed [ACT_W-1:0] A16,
  input  logic signed [ACT_W-1:0] A17,
  input  logic signed [ACT_W-1:0] A18,
  input  logic signed [ACT_W-1:0] A19,
  input  logic signed [ACT_W-1:0] A20,
  input  logic        [1:0]       W1,
  input  logic        [1:0]       W2,
  input  logic        [1:0]       W3,
  input  logic        [1:0]       W4,
  input  logic        [1:0]       W5,
  input  logic        [1:0]       W6,
  input  logic        [1:0]       W7,
  input  logic        [1:0]       W8,
  input  logic        [1:0]       W9,
  input  logic        [1:0]       W10,
  input  logic        [1:0]       W11,
  input  logic        [1:0]       W12,
  input  logic        [1:0]       W13,
  input  logic        [1:0]       W14,
  input  logic        [1:0]       W15,
  input  logic        [1:0]       W16,
  input  logic        [1:0]       W17,
  input  logic        [1:0]       W18,
  input  logic        [1:0]       W19,
  input  logic        [1:0]       W20,
  input  logic                    clk,
  input  logic                    rst,
  output logic signed [OUT_W-1:0] out_neuron
);

  localparam int unsigned NumLanes = 20;
  // One extra bit so that negating the most negative activation is exact.
  localparam int unsigned TermW = ACT_W + 1;
  // 20 terms need 5 growth bits. The floor of 15 bits keeps the default
  // configuration wide enough, and OUT_W+1 keeps the saturation compare valid.
  localparam int unsigned SumA = (TermW + 5 > 15) ? TermW + 5 : 15;
  localparam int unsigned SumW = (SumA > OUT_W + 1) ? SumA : OUT_W + 1;

  localparam logic signed [SumW-1:0] SatMax =
      $signed({{(SumW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [SumW-1:0] SatMin =
      $signed({{(SumW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}});
  localparam logic signed [OUT_W-1:0] OutMax = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OutMin = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [ACT_W-1:0] w_act  [NumLanes];
  logic        [1:0]       w_wgt  [NumLanes];
  logic signed [TermW-1:0] w_term [NumLanes];
  logic signed [TermW-1:0] r_term [NumLanes];
  logic signed [SumW-1:0]  w_sum;
  logic signed [OUT_W-1:0] w_sat;

  assign w_act = '{A1, A2, A3, A4, A5, A6, A7, A8, A9, A10,
                   A11, A12, A13, A14, A15, A16, A17, A18, A19, A20};
  assign w_wgt = '{W1, W2, W3, W4, W5, W6, W7, W8, W9, W10,
                   W11, W12, W13, W14, W15, W16, W17, W18, W19, W20};

  // Weight decode: the reserved code 2'b10 contributes nothing, like 2'b00.
  always_comb begin
    for (int i = 0; i < NumLanes; i++) begin
      w_term[i] = '0;
      case (w_wgt[i])
        2'b01:   w_term[i] = {w_act[i][ACT_W-1], w_act[i]};
        2'b11:   w_term[i] = -{w_act[i][ACT_W-1], w_act[i]};
        default: w_term[i] = '0;
      endcase
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NumLanes; i++) begin
      w_sum = w_sum + {{(SumW - TermW){r_term[i][TermW-1]}}, r_term[i]};
    end
  end

  always_comb begin
    if (w_sum > SatMax) begin
      w_sat = OutMax;
    end else if (w_sum < SatMin) begin
      w_sat = OutMin;
    end else begin
      w_sat = w_sum[OUT_W-1:0];
    end
`ifdef AIM_RELU_EN
    if (w_sat[OUT_W-1]) begin
      w_sat = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumLanes; i++) begin
        r_term[i] <= '0;
      end
      out_neuron <= '0;
    end else begin
      for (int i = 0; i < NumLanes; i++) begin
        r_term[i] <= w_term[i];
      end
      out_neuron <= w_sat;
    end
  end

endmodule

// File: tb/tb_aim_neuron.sv
// Self-checking bench for aim_neuron. Inputs are driven and outputs sampled
// on the falling edge. The expected values come from a plain integer model
// of the dot product, followed by a clamp and an optional ReLU.
module tb_aim_neuron;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [8:0]  a_v [20];
  logic        [1:0]  w_v [20];
  logic signed [12:0] out_neuron;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aim_neuron dut (
    .A1(a_v[0]),   .A2(a_v[1]),   .A3(a_v[2]),   .A4(a_v[3]),   .A5(a_v[4]),
    .A6(a_v[5]),   .A7(a_v[6]),   .A8(a_v[7]),   .A9(a_v[8]),   .A10(a_v[9]),
    .A11(a_v[10]), .A12(a_v[11]), .A13(a_v[12]), .A14(a_v[13]), .A15(a_v[14]),
    .A16(a_v[15]), .A17(a_v[16]), .A18(a_v[17]), .A19(a_v[18]), .A20(a_v[19]),
    .W1(w_v[0]),   .W2(w_v[1]),   .W3(w_v[2]),   .W4(w_v[3]),   .W5(w_v[4]),
    .W6(w_v[5]),   .W7(w_v[6]),   .W8(w_v[7]),   .W9(w_v[8]),   .W10(w_v[9]),
    .W11(w_v[10]), .W12(w_v[11]), .W13(w_v[12]), .W14(w_v[13]), .W15(w_v[14]),
    .W16(w_v[15]), .W17(w_v[16]), .W18(w_v[17]), .W19(w_v[18]), .W20(w_v[19]),
    .clk(clk),
    .rst(rst),
    .out_neuron(out_neuron)
  );

  // Reference: ternary dot product in plain integers, then clamp (and ReLU).
  function automatic int model_out();
    int s = 0;
    for (int i = 0; i < 20; i++) begin
      if (w_v[i] == 2'b01) s += int'(a_v[i]);
      else if (w_v[i] == 2'b11) s -= int'(a_v[i]);
    end
    if (s > 4095) s = 4095;
    if (s < -4096) s = -4096;
`ifdef AIM_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic set_all(input int a, input int w);
    for (int i = 0; i < 20; i++) begin
      a_v[i] = 9'(a);
      w_v[i] = 2'(w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_v[i] = 9'($urandom_range(0, 511));
      w_v[i] = 2'($urandom_range(0, 3));
    end
    repeat (2) @(negedge clk);
    total++;
    if (out_neuron !== 13'sd0) begin
      bad++;
      $display("FAIL reset_hold: got %0d want 0", out_neuron);
    end
    // Release reset with non-zero data applied: one more edge of zero output.
    rst = 1'b0;
    set_all(7, 1);
    @(negedge clk);
    total++;
    if (out_neuron !== 13'sd0) begin
      bad++;
      $display("FAIL reset_first_edge: got %0d want 0", out_neuron);
    end
    @(negedge clk);
    total++;
    if (int'(out_neuron) != 140) begin
      bad++;
      $display("FAIL reset_first_result: got %0d want 140", out_neuron);
    end
  endtask

  task automatic test_mixed();
    int a_tab [20] = '{0, 52, -41, 0, -12, 115, 95, 0, 5, 115,
                       0, 52, -41, 0, -12, 115, 95, 0, 5, -65};
    int w_tab [20] = '{1, -1, 0, 0, -1, 1, 0, -1, 1, 0,
                       1, -1, 0, 0, -1, 1, 0, -1, 1, 0};
    for (int i = 0; i < 20; i++) begin
      a_v[i] = 9'(a_tab[i]);
      w_v[i] = 2'(w_tab[i]);
    end
    repeat (2) @(negedge clk);
    total++;
    if (int'(out_neuron) != 160) begin
      bad++;
      $display("FAIL mixed_vector: got %0d want 160", out_neuron);
    end
  endtask

  task automatic test_saturation();
    int exp_neg;
`ifdef AIM_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -4096;
`endif
    set_all(255, 1);
    repeat (2) @(negedge clk);
    total++;
    if (int'(out_neuron) != 4095) begin
      bad++;
      $display("FAIL pos_sat_5100: got %0d want 4095", out_neuron);
    end
    set_all(-256, 3);
    repeat (2) @(negedge clk);
    total++;
    if (int'(out_neuron) != 4095) begin
      bad++;
      $display("FAIL pos_sat_5120: got %0d want 4095", out_neuron);
    end
    set_all(-256, 1);
    repeat (2) @(negedge clk);
    total++;
    if (int'(out_neuron) != exp_neg) begin
      bad++;
      $display("FAIL neg_sat_5120: got %0d want %0d", out_neuron, exp_neg);
    end
  endtask

  // Exact boundaries: sums of 4095, 4096, -4096 and -4097.
  task automatic test_boundaries();
    int sums [4] = '{4095, 4096, -4096, -4097};
    int exp;
    for (int k = 0; k < 4; k++) begin
      int rem = sums[k];
      int sgn = (rem < 0) ? -1 : 1;
      set_all(0, 0);
      // Use 255 per lane with +1 weights (or -255 for negatives), then the remainder.
      for (int i = 0; i < 20 && rem != 0; i++) begin
        int mag = (rem * sgn > 255) ? 255 : rem * sgn;
        a_v[i] = 9'(mag * sgn);
        w_v[i] = 2'b01;
        rem -= mag * sgn;
      end
      exp = model_out();
      repeat (2) @(negedge clk);
      total++;
      if (int'(out_neuron) != exp) begin
        bad++;
        $display("FAIL boundary_%0d: got %0d want %0d", sums[k], out_neuron, exp);
      end
    end
  endtask

  task automatic test_reserved();
    set_all(100, 2);
    repeat (2) @(negedge clk);
    total++;
    if (out_neuron !== 13'sd0) begin
      bad++;
      $display("FAIL reserved_all: got %0d want 0", out_neuron);
    end
    set_all(100, 0);
    repeat (2) @(negedge clk);
    total++;
    if (out_neuron !== 13'sd0) begin
      bad++;
      $display("FAIL zero_weights: got %0d want 0", out_neuron);
    end
    set_all(100, 2);
    w_v[0] = 2'b01;
    repeat (2) @(negedge clk);
    total++;
    if (int'(out_neuron) != 100) begin
      bad++;
      $display("FAIL reserved_one_lane: got %0d want 100", out_neuron);
    end
  endtask

  task automatic test_back_to_back();
    int seq_a [3] = '{10, 20, 30};
    int seq_w [3] = '{1, 3, 1};
    int exp   [3] = '{10, -20, 30};
`ifdef AIM_RELU_EN
    exp[1] = 0;
`endif
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) begin
        total++;
        if (int'(out_neuron) != exp[k-2]) begin
          bad++;
          $display("FAIL back_to_back_%0d: got %0d want %0d", k - 2, out_neuron, exp[k-2]);
        end
      end
      if (k < 3) begin
        set_all(0, 0);
        a_v[0] = 9'(seq_a[k]);
        w_v[0] = 2'(seq_w[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midstream_reset();
    int exp;
    set_all(77, 1);
    @(negedge clk);
    set_all(33, 3);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_neuron !== 13'sd0) begin
      bad++;
      $display("FAIL midreset_edge: got %0d want 0", out_neuron);
    end
    rst = 1'b0;
    set_all(0, 0);
    a_v[3] = 9'sd42;
    w_v[3] = 2'b11;
    exp = model_out();
    @(negedge clk);
    total++;
    if (out_neuron !== 13'sd0) begin
      bad++;
      $display("FAIL midreset_next: got %0d want 0", out_neuron);
    end
    @(negedge clk);
    total++;
    if (int'(out_neuron) != exp) begin
      bad++;
      $display("FAIL midreset_resume: got %0d want %0d", out_neuron, exp);
    end
  endtask

  task automatic test_random();
    int exp_q [$];
    for (int k = 0; k < 302; k++) begin
      if (k >= 2) begin
        int e = exp_q.pop_front();
        total++;
        if (int'(out_neuron) != e) begin
          bad++;
          $display("FAIL random_%0d: got %0d want %0d", k - 2, out_neuron, e);
        end
      end
      if (k < 300) begin
        if (k % 4 == 0) begin
          // Biased vectors push the sum towards the saturation rails.
          int w = $urandom_range(0, 1) ? 1 : 3;
          for (int i = 0; i < 20; i++) begin
            a_v[i] = $urandom_range(0, 1) ? 9'sd255 : -9'sd256;
            w_v[i] = ($urandom_range(0, 7) == 0) ? 2'(w ^ 2) : 2'(w);
          end
        end else begin
          for (int i = 0; i < 20; i++) begin
            a_v[i] = 9'($urandom_range(0, 511));
            w_v[i] = 2'($urandom_range(0, 3));
          end
        end
        exp_q.push_back(model_out());
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    set_all(0, 0);
    @(negedge clk);
    test_reset();
    test_mixed();
    test_saturation();
    test_boundaries();
    test_reserved();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
